// File: rtl/div_enable_gen_if.sv
// Handshake/config bundle between a sequencer and the enable-strobe generator.
// The master drives requests and configuration; the slave returns the strobe and status.
interface div_enable_gen_if #(
    parameter int PRESCALE_W = 8,
    parameter int BURST_W    = 8
);
    logic                  start;
    logic                  stop;
    logic                  mode;
    logic [PRESCALE_W-1:0] prescale;
    logic [BURST_W-1:0]    burst_len;
    logic                  enb;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stop, mode, prescale, burst_len,
        input  enb, busy, done
    );

    modport slave (
        input  start, stop, mode, prescale, burst_len,
        output enb, busy, done
    );
endinterface

// File: rtl/div_enable_gen.sv
// Programmable enable-strobe generator feeding the clock divider's enb input:
// one-cycle strobe every P+1 cycles, continuous or for a counted burst of N strobes.
module div_enable_gen #(
    parameter int PRESCALE_W = 8,
    parameter int BURST_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    div_enable_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [BURST_W-1:0]    bcnt_q, bcnt_d;
    logic [BURST_W-1:0]    n_q, n_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;

    logic active;
    logic strobe;

    // Strobe is decoded purely from registers so the divider sees a glitch-free enable.
    assign active = (state_q == RUN) || (state_q == BURST);
    assign strobe = active && (pcnt_q == p_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            p_q     <= '0;
            bcnt_q  <= '0;
            n_q     <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            p_q     <= p_d;
            bcnt_q  <= bcnt_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        p_d     = p_q;
        bcnt_d  = bcnt_q;
        n_d     = n_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A simultaneous stop vetoes the start.
                if (bus.start && !bus.stop) begin
                    p_d    = bus.prescale;
                    n_d    = bus.burst_len;
                    mode_d = bus.mode;
                    pcnt_d = '0;
                    bcnt_d = '0;
                    if (!bus.mode) begin
                        state_d = RUN;
                    end else if (bus.burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = BURST;
                    end
                end
            end

            RUN, BURST: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = strobe ? '0 : pcnt_q + PRESCALE_W'(1);
                    if ((state_q == BURST) && strobe) begin
                        // N >= 1 is guaranteed here, so N-1 cannot underflow.
                        if (bcnt_q == n_q - BURST_W'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + BURST_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.enb  = strobe;
    assign bus.busy = active;
    assign bus.done = done_q;

endmodule

// File: tb/tb_div_enable_gen.sv
// Directed bench for div_enable_gen: reset, continuous, burst, stop, corner cases,
// and a 3-bit divider chained on enb.
module tb_div_enable_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int errors = 0;
    int checks = 0;

    div_enable_gen_if #(.PRESCALE_W(8), .BURST_W(8)) bus ();

    div_enable_gen #(.PRESCALE_W(8), .BURST_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Downstream three-bit divider advanced by each strobe.
    logic       div_clr = 1'b1;
    logic [2:0] div_cnt;
    always @(posedge clk) begin
        if (div_clr)      div_cnt <= 3'd0;
        else if (bus.enb) div_cnt <= div_cnt + 3'd1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".enb"},  32'(bus.enb),  32'd0);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".done"}, 32'(bus.done), 32'd0);
    endtask

    int strobes;

    initial begin
        bus.start     = 1'b1;
        bus.stop      = 1'b0;
        bus.mode      = 1'b0;
        bus.prescale  = 8'd0;
        bus.burst_len = 8'd0;

        // Reset held 3 cycles with start asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("reset");
        end
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        check_idle("post_reset");

        // Continuous, P=2; config wiggles and a stray start must be ignored
        bus.mode = 1'b0; bus.prescale = 8'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.prescale = 8'd0; bus.mode = 1'b1; bus.burst_len = 8'd1;
        for (int i = 0; i < 12; i++) begin
            check("cont.enb",  32'(bus.enb),  (i % 3 == 2) ? 32'd1 : 32'd0);
            check("cont.busy", 32'(bus.busy), 32'd1);
            check("cont.done", 32'(bus.done), 32'd0);
            bus.start = (i == 4);
            tick();
        end
        bus.start = 1'b0;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("cont_stop");

        // Burst, P=0, N=4
        bus.mode = 1'b1; bus.prescale = 8'd0; bus.burst_len = 8'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("burst.enb",  32'(bus.enb),  32'd1);
            check("burst.busy", 32'(bus.busy), 32'd1);
            check("burst.done", 32'(bus.done), 32'd0);
            tick();
        end
        check("burst_end.done", 32'(bus.done), 32'd1);
        check("burst_end.busy", 32'(bus.busy), 32'd0);
        check("burst_end.enb",  32'(bus.enb),  32'd0);
        tick();
        check_idle("burst_after");

        // Burst P=1, N=5, stop sampled during the 3rd strobe
        bus.mode = 1'b1; bus.prescale = 8'd1; bus.burst_len = 8'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            check("stop.enb", 32'(bus.enb), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (bus.enb) strobes++;
            bus.stop = (i == 5);
            tick();
        end
        bus.stop = 1'b0;
        check("stop.strobes", 32'(strobes), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_idle("stop_after");
            tick();
        end

        // Start and stop together in IDLE: nothing happens
        bus.mode = 1'b0; bus.prescale = 8'd0; bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check_idle("start_stop");
        tick();
        check_idle("start_stop2");

        // Burst with N=0: immediate done, no strobe
        bus.mode = 1'b1; bus.prescale = 8'd0; bus.burst_len = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("n0.done", 32'(bus.done), 32'd1);
        check("n0.busy", 32'(bus.busy), 32'd0);
        check("n0.enb",  32'(bus.enb),  32'd0);
        tick();
        check_idle("n0_after");

        // Reset mid-burst, N=10, after 5 strobes
        bus.mode = 1'b1; bus.prescale = 8'd0; bus.burst_len = 8'd10; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rstmid.enb", 32'(bus.enb), 32'd1);
            if (i == 4) rst = 1'b0;
            tick();
        end
        check_idle("rstmid");
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_idle("rstmid_after");
        end

        // Chained divider, continuous P=1: div_cnt steps every 2 cycles
        bus.mode = 1'b0; bus.prescale = 8'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        div_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("div.cnt", 32'(div_cnt), 32'((i / 2) % 8));
            tick();
        end
        check("div.wrap", 32'(div_cnt), 32'd0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("div_stop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
